// File: rtl/wormy_pkg.sv
// Shared constants and types for the keypad scanner and its helpers.
package wormy_pkg;

    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;
    localparam int NUM_KEYS = NUM_COLS * NUM_ROWS;

    typedef logic [3:0]  key_code_t;
    typedef logic [15:0] key_mask_t;

    // One-hot column strobe for a column index.
    function automatic logic [NUM_COLS-1:0] col_onehot(input logic [1:0] col);
        logic [NUM_COLS-1:0] strobe;
        case (col)
            2'd0:    strobe = 4'b0001;
            2'd1:    strobe = 4'b0010;
            2'd2:    strobe = 4'b0100;
            2'd3:    strobe = 4'b1000;
            default: strobe = 4'b0001;
        endcase
        return strobe;
    endfunction

endpackage

// File: rtl/key_priority_enc.sv
// Combinational 16->4 lowest-set-bit encoder with a valid flag.
module key_priority_enc
    import wormy_pkg::*;
(
    input  key_mask_t mask,
    output key_code_t code,
    output logic      valid
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        code  = 4'd0;
        valid = 1'b0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            code  = mask[i] ? key_code_t'(i) : code;
            valid = valid | mask[i];
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 key matrix scanner: column strobing, row sampling, frame debounce,
// and a one-cycle new-key event carrying the lowest newly pressed key code.
module keypad_scanner
    import wormy_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  rows,
    output logic [3:0]  cols_out,
    output logic [15:0] keys_down,
    output logic        key_pushed,
    output logic [3:0]  key_code
);

    localparam int SW = $clog2(SETTLE_CYCLES);
    localparam int MW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [MW-1:0] MATCH_LAST  = MW'(DEBOUNCE_SCANS - 1);

    logic [3:0]    sync1_r;
    logic [3:0]    sync2_r;
    logic [SW-1:0] settle_r;
    logic [1:0]    col_r;
    logic [3:0]    cols_r;
    logic [11:0]   raw_r;
    key_mask_t     prev_r;
    logic [MW-1:0] match_r;
    key_mask_t     keys_down_r;
    logic          key_pushed_r;
    key_code_t     key_code_r;

    logic          sample_s;
    logic          frame_end_s;
    key_mask_t     frame_s;
    logic [MW-1:0] match_next_s;
    logic          commit_s;
    key_mask_t     new_s;
    key_code_t     new_code_s;
    logic          new_valid_s;

    // The column-3 rows come straight from the synchronizer, so only
    // columns 0..2 need raw storage to assemble the completed frame.
    always_comb begin
        sample_s     = (settle_r == SETTLE_LAST);
        frame_end_s  = sample_s && (col_r == 2'd3);
        frame_s      = {sync2_r, raw_r};
        new_s        = frame_s & ~keys_down_r;
        match_next_s = {MW{1'b0}};
        if (frame_s == prev_r) begin
            if (match_r == MATCH_LAST) begin
                match_next_s = match_r;
            end else begin
                match_next_s = match_r + MW'(1);
            end
        end else begin
            match_next_s = {MW{1'b0}};
        end
        if (frame_end_s && (match_next_s == MATCH_LAST) && (frame_s != keys_down_r)) begin
            commit_s = 1'b1;
        end else begin
            commit_s = 1'b0;
        end
    end

    key_priority_enc u_new_enc (
        .mask  (new_s),
        .code  (new_code_s),
        .valid (new_valid_s)
    );

    // Synchronizer, column sequencer, frame debounce and committed outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r      <= 4'd0;
            sync2_r      <= 4'd0;
            settle_r     <= {SW{1'b0}};
            col_r        <= 2'd0;
            cols_r       <= 4'b0001;
            raw_r        <= 12'd0;
            prev_r       <= 16'd0;
            match_r      <= {MW{1'b0}};
            keys_down_r  <= 16'd0;
            key_pushed_r <= 1'b0;
            key_code_r   <= 4'd0;
        end else begin
            sync1_r      <= rows;
            sync2_r      <= sync1_r;
            key_pushed_r <= 1'b0;
            if (sample_s) begin
                settle_r <= {SW{1'b0}};
                col_r    <= col_r + 2'd1;
                cols_r   <= col_onehot(col_r + 2'd1);
                case (col_r)
                    2'd0:    raw_r[3:0]  <= sync2_r;
                    2'd1:    raw_r[7:4]  <= sync2_r;
                    2'd2:    raw_r[11:8] <= sync2_r;
                    default: raw_r       <= raw_r;
                endcase
            end else begin
                settle_r <= settle_r + SW'(1);
            end
            if (frame_end_s) begin
                match_r <= match_next_s;
                prev_r  <= frame_s;
            end
            if (commit_s) begin
                keys_down_r <= frame_s;
                if (new_valid_s) begin
                    key_pushed_r <= 1'b1;
                    key_code_r   <= new_code_s;
                end
            end
        end
    end

    assign cols_out   = cols_r;
    assign keys_down  = keys_down_r;
    assign key_pushed = key_pushed_r;
    assign key_code   = key_code_r;

endmodule
